// File: rtl/pipe_reg.sv
// Elastic register pipeline with valid/ready handshake, bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  logic [DEPTH:0]   r;
  logic             up_v [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // Each stage is fed by the stage before it; stage 0 is fed by the input port.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_up
    if (gi == 0) begin : g_first
      assign up_v[gi] = in_valid;
      assign up_d[gi] = in_data;
    end else begin : g_inner
      assign up_v[gi] = v_q[gi-1];
      assign up_d[gi] = d_q[gi-1];
    end
  end

  // A stage can take a new word if it is empty or its own word moves on.
  always_comb begin
    r        = '0;
    r[DEPTH] = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      r[k] = !v_q[k] | r[k+1];
    end
  end

  assign in_ready  = r[0] & ~flush;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    v_d   = v_q;
    occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    for (int k = 0; k < int'(DEPTH); k++) begin
      d_d[k] = d_q[k];
      if (r[k]) begin
        v_d[k] = up_v[k];
      end
      // Data only moves with a valid word, so empty stages keep their old contents.
      if (r[k] && up_v[k] && !flush) begin
        d_d[k] = up_d[k];
      end
    end
    if (flush) begin
      v_d   = '0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        d_q[k] <= RESET_VAL;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Directed, table-driven check of pipe_reg (WIDTH=32, DEPTH=3) plus a
// hand-written back-pressure / drain sequence.
module tb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_reg #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  typedef struct {
    string       tag;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string tag, logic r, logic fl, logic iv, logic [31:0] dat,
                              logic ordy, logic ir, logic ov, logic [31:0] od, logic [1:0] occ);
    vec_t v;
    v.tag = tag; v.rst = r; v.flush = fl; v.in_valid = iv; v.in_data = dat;
    v.out_ready = ordy; v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_occ = occ;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] words [3];
  logic [31:0] model [$];
  logic [31:0] exp_w;
  int          idx;

  initial begin
    // reset, idle
    vecs.push_back(mk("idle",    0,0,0,32'h00,1, 1,0,32'h00,0));
    // back-to-back stream
    vecs.push_back(mk("s11",     0,0,1,32'h11,1, 1,0,32'h00,0));
    vecs.push_back(mk("s22",     0,0,1,32'h22,1, 1,0,32'h00,1));
    vecs.push_back(mk("s33",     0,0,1,32'h33,1, 1,0,32'h00,2));
    vecs.push_back(mk("s44",     0,0,1,32'h44,1, 1,1,32'h11,3));
    vecs.push_back(mk("sdrn1",   0,0,0,32'h00,1, 1,1,32'h22,3));
    vecs.push_back(mk("sdrn2",   0,0,0,32'h00,1, 1,1,32'h33,2));
    vecs.push_back(mk("sdrn3",   0,0,0,32'h00,1, 1,1,32'h44,1));
    vecs.push_back(mk("sempty",  0,0,0,32'h00,1, 1,0,32'h44,0));
    // back-pressure fill, then release
    vecs.push_back(mk("bpA0",    0,0,1,32'hA0,0, 1,0,32'h44,0));
    vecs.push_back(mk("bpA1",    0,0,1,32'hA1,0, 1,0,32'h44,1));
    vecs.push_back(mk("bpA2",    0,0,1,32'hA2,0, 1,0,32'h44,2));
    vecs.push_back(mk("bpA3a",   0,0,1,32'hA3,0, 0,1,32'hA0,3));
    vecs.push_back(mk("bpA3b",   0,0,1,32'hA3,0, 0,1,32'hA0,3));
    vecs.push_back(mk("bpA3go",  0,0,1,32'hA3,1, 1,1,32'hA0,3));
    vecs.push_back(mk("bpA4",    0,0,1,32'hA4,1, 1,1,32'hA1,3));
    vecs.push_back(mk("bpd1",    0,0,0,32'h00,1, 1,1,32'hA2,3));
    vecs.push_back(mk("bpd2",    0,0,0,32'h00,1, 1,1,32'hA3,2));
    vecs.push_back(mk("bpd3",    0,0,0,32'h00,1, 1,1,32'hA4,1));
    vecs.push_back(mk("bpempty", 0,0,0,32'h00,1, 1,0,32'hA4,0));
    // fill, then full-rate pass-through
    vecs.push_back(mk("fB0",     0,0,1,32'hB0,0, 1,0,32'hA4,0));
    vecs.push_back(mk("fB1",     0,0,1,32'hB1,0, 1,0,32'hA4,1));
    vecs.push_back(mk("fB2",     0,0,1,32'hB2,0, 1,0,32'hA4,2));
    vecs.push_back(mk("fB3",     0,0,1,32'hB3,1, 1,1,32'hB0,3));
    vecs.push_back(mk("fB4",     0,0,1,32'hB4,1, 1,1,32'hB1,3));
    vecs.push_back(mk("fB5",     0,0,1,32'hB5,1, 1,1,32'hB2,3));
    vecs.push_back(mk("fB6",     0,0,1,32'hB6,1, 1,1,32'hB3,3));
    vecs.push_back(mk("fB7",     0,0,1,32'hB7,1, 1,1,32'hB4,3));
    vecs.push_back(mk("fdrn",    0,0,0,32'h00,1, 1,1,32'hB5,3));
    // flush at occupancy 2 with a word offered
    vecs.push_back(mk("flush",   0,1,1,32'h55,0, 0,0,32'hB6,2));
    vecs.push_back(mk("pflush1", 0,0,0,32'h00,1, 1,0,32'hB6,0));
    vecs.push_back(mk("pflush2", 0,0,0,32'h00,1, 1,0,32'hB6,0));
    vecs.push_back(mk("pflush3", 0,0,0,32'h00,1, 1,0,32'hB6,0));
    // full pipe, reset with flush and out_ready
    vecs.push_back(mk("gC0",     0,0,1,32'hC0,0, 1,0,32'hB6,0));
    vecs.push_back(mk("gC1",     0,0,1,32'hC1,0, 1,0,32'hB6,1));
    vecs.push_back(mk("gC2",     0,0,1,32'hC2,0, 1,0,32'hB6,2));
    vecs.push_back(mk("rstfl",   1,1,1,32'h99,1, 0,0,32'hC0,3));
    vecs.push_back(mk("r77",     0,0,1,32'h77,1, 1,0,32'h00,0));
    vecs.push_back(mk("r77w1",   0,0,0,32'h00,1, 1,0,32'h00,1));
    vecs.push_back(mk("r77w2",   0,0,0,32'h00,1, 1,0,32'h00,1));
    vecs.push_back(mk("r77out",  0,0,0,32'h00,1, 1,1,32'h77,1));
    vecs.push_back(mk("r77gone", 0,0,0,32'h00,1, 1,0,32'h77,0));

    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      flush     = vecs[i].flush;
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      #1;
      check({vecs[i].tag, ".in_ready"},  {31'h0, in_ready},  {31'h0, vecs[i].e_ir});
      check({vecs[i].tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, vecs[i].e_ov});
      check({vecs[i].tag, ".out_data"},  out_data,           vecs[i].e_od);
      check({vecs[i].tag, ".occupancy"}, {30'h0, occupancy}, {30'h0, vecs[i].e_occ});
      $display("vec %0d %s: ir=%0b ov=%0b od=%h occ=%0d", i, vecs[i].tag,
               in_ready, out_valid, out_data, occupancy);
    end

    // Hand sequence: fill under back-pressure, hold, then drain in order.
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    words[0] = 32'hE0; words[1] = 32'hE1; words[2] = 32'hE2;
    idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      in_valid = 1'b1;
      in_data  = words[idx];
      #1;
      if (in_ready) begin
        model.push_back(words[idx]);
        $display("seq push %h", words[idx]);
        idx++;
      end
      @(negedge clk);
    end
    check("seq.accepted", idx, 3);
    in_valid = 1'b1;
    in_data  = 32'hE3;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("seq.hold_ir",  {31'h0, in_ready},  32'h0);
      check("seq.hold_ov",  {31'h0, out_valid}, 32'h1);
      check("seq.hold_od",  out_data,           model[0]);
      check("seq.hold_occ", {30'h0, occupancy}, 32'h3);
      $display("seq hold %0d: ov=%0b od=%h occ=%0d", c, out_valid, out_data, occupancy);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && model.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        exp_w = model.pop_front();
        check("seq.drain_od", out_data, exp_w);
        $display("seq pop %h", out_data);
      end
      @(negedge clk);
    end
    check("seq.drained", model.size(), 0);
    #1;
    check("seq.empty_ov",  {31'h0, out_valid}, 32'h0);
    check("seq.empty_occ", {30'h0, occupancy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
